// File: rtl/ahb3lite_slave_port_arbiter.sv
// ahb3lite_slave_port_arbiter
// Per-slave-port master arbiter for the AHB3-Lite interconnect switch.
// Picks the highest-priority requester at each arbitration point. Fixed-length
// bursts and locked sequences are never broken up. The grant is registered and
// drives the slave-side address/data muxes.
// Optional feature macro: AHB_ARB_ROUND_ROBIN_EN. When it is defined, an
// equal-priority tie goes to the first requester after rr_ptr, wrapping around.
// When it is not defined, the tie goes to the lowest index. rr_ptr is tracked
// in both builds.
module ahb3lite_slave_port_arbiter #(
  parameter int MASTERS       = 3,
  parameter int PRIORITY_BITS = 3,
  localparam int IDX_W        = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [MASTERS-1:0]                 mst_req,
  input  logic [MASTERS*PRIORITY_BITS-1:0]   mst_priority,
  input  logic [MASTERS*2-1:0]               mst_HTRANS,
  input  logic [MASTERS*3-1:0]               mst_HBURST,
  input  logic [MASTERS-1:0]                 mst_HMASTLOCK,
  input  logic                               HREADY,
  output logic [MASTERS-1:0]                 grant,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic                               grant_valid,
  output logic                               arb_locked
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [MASTERS-1:0] grant_reg;
  logic [IDX_W-1:0]   grant_idx_reg;
  logic               grant_valid_reg;
  logic               arb_locked_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [3:0]         beat_cnt_reg;

  // Per-master views of the packed input buses
  logic [PRIORITY_BITS-1:0] prio_arr  [MASTERS];
  logic [1:0]               trans_arr [MASTERS];
  logic [2:0]               burst_arr [MASTERS];
  logic [MASTERS-1:0]       win_onehot;

  logic [IDX_W-1:0] win_idx;

  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_unpack
      assign prio_arr[gi]   = mst_priority[gi*PRIORITY_BITS +: PRIORITY_BITS];
      assign trans_arr[gi]  = mst_HTRANS[gi*2 +: 2];
      assign burst_arr[gi]  = mst_HBURST[gi*3 +: 3];
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Current owner's bus signals
  logic       owner_req;
  logic       owner_lock;
  logic [1:0] owner_trans;
  logic [2:0] owner_burst;

  assign owner_req   = mst_req[grant_idx_reg];
  assign owner_lock  = mst_HMASTLOCK[grant_idx_reg];
  assign owner_trans = trans_arr[grant_idx_reg];
  assign owner_burst = burst_arr[grant_idx_reg];

  // Winner's signals decide the tenure type it enters
  logic       win_lock;
  logic [1:0] win_trans;
  logic [2:0] win_burst;

  assign win_lock  = mst_HMASTLOCK[win_idx];
  assign win_trans = trans_arr[win_idx];
  assign win_burst = burst_arr[win_idx];

  // WRAP4/INCR4 -> 3, WRAP8/INCR8 -> 7, WRAP16/INCR16 -> 15 remaining beats
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst)
      3'd2, 3'd3: burst_beats_m1 = 4'd3;
      3'd4, 3'd5: burst_beats_m1 = 4'd7;
      3'd6, 3'd7: burst_beats_m1 = 4'd15;
      default:    burst_beats_m1 = 4'd0;
    endcase
  endfunction

  // Winner search: highest priority first, then the tie-break order
  logic [PRIORITY_BITS-1:0] max_prio;
  logic [MASTERS-1:0]       eligible;
  logic                     any_req;
  logic                     found_lo;
  logic                     found_hi;
  logic [IDX_W-1:0]         lo_idx;
  logic [IDX_W-1:0]         hi_idx;

  always_comb begin
    max_prio = '0;
    eligible = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    any_req  = |mst_req;
    for (int m = 0; m < MASTERS; m++) begin
      if (mst_req[m] && (prio_arr[m] > max_prio)) max_prio = prio_arr[m];
    end
    for (int m = 0; m < MASTERS; m++) begin
      eligible[m] = mst_req[m] && (prio_arr[m] == max_prio);
    end
    for (int m = 0; m < MASTERS; m++) begin
      if (!found_lo && eligible[m]) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(m);
      end
      if (!found_hi && eligible[m] && (IDX_W'(m) > rr_ptr_reg)) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(m);
      end
    end
`ifdef AHB_ARB_ROUND_ROBIN_EN
    // Search above rr_ptr first, then wrap to the lowest eligible index
    win_idx = found_hi ? hi_idx : lo_idx;
`else
    win_idx = lo_idx;
`endif
  end

  // Arbitration point. HREADY is applied separately in the sequential block.
  logic ap;

  always_comb begin
    case (state_reg)
      ST_IDLE:  ap = 1'b1;
      ST_OWN:   ap = !owner_req || (owner_trans == HTRANS_IDLE) ||
                     ((owner_trans == HTRANS_NONSEQ) &&
                      ((owner_burst == HBURST_SINGLE) || (owner_burst == HBURST_INCR)));
      // A NONSEQ or IDLE from the owner ends the burst early
      ST_BURST: ap = !owner_lock && ((beat_cnt_reg == 4'd0) ||
                     (owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_IDLE));
      ST_LOCK:  ap = !owner_lock && (owner_trans == HTRANS_IDLE);
      default:  ap = 1'b0;
    endcase
  end

  // Tenure FSM. Grant, rr_ptr and the beat counter all advance only on HREADY.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
      arb_locked_reg  <= 1'b0;
      rr_ptr_reg      <= IDX_W'(MASTERS - 1);
      beat_cnt_reg    <= 4'd0;
    end else if (HREADY) begin
      if (ap) begin
        if (any_req) begin
          grant_reg       <= win_onehot;
          grant_idx_reg   <= win_idx;
          grant_valid_reg <= 1'b1;
          // Keeping the same owner leaves the round-robin pointer where it is
          if (!(grant_valid_reg && (win_idx == grant_idx_reg)) && (win_idx != rr_ptr_reg))
            rr_ptr_reg <= win_idx;
          if (win_lock) begin
            state_reg      <= ST_LOCK;
            arb_locked_reg <= 1'b1;
            beat_cnt_reg   <= 4'd0;
          end else if ((win_trans == HTRANS_NONSEQ) && (win_burst >= 3'd2)) begin
            state_reg      <= ST_BURST;
            arb_locked_reg <= 1'b1;
            beat_cnt_reg   <= burst_beats_m1(win_burst);
          end else begin
            state_reg      <= ST_OWN;
            arb_locked_reg <= 1'b0;
            beat_cnt_reg   <= 4'd0;
          end
        end else begin
          state_reg       <= ST_IDLE;
          grant_reg       <= '0;
          grant_valid_reg <= 1'b0;
          arb_locked_reg  <= 1'b0;
          beat_cnt_reg    <= 4'd0;
        end
      end else if ((state_reg == ST_BURST) && (owner_trans == HTRANS_SEQ) &&
                   (beat_cnt_reg != 4'd0)) begin
        beat_cnt_reg <= beat_cnt_reg - 4'd1;
      end
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = grant_idx_reg;
  assign grant_valid = grant_valid_reg;
  assign arb_locked  = arb_locked_reg;

endmodule

// File: tb/tb_ahb3lite_slave_port_arbiter.sv
// Bench for ahb3lite_slave_port_arbiter: a vector table plus hand-written
// HREADY/BUSY stall sequences. The expected outputs of each cycle go into a
// scoreboard queue and are compared after the clock edge.
`timescale 1ns/1ps
module tb_ahb3lite_slave_port_arbiter;

  localparam logic [1:0] TI = 2'd0, TB = 2'd1, TN = 2'd2, TS = 2'd3;
  localparam int SGL = 0, INC = 1, INC4 = 3, INC8 = 5;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [2:0] mst_req;
  logic [8:0] mst_priority;
  logic [5:0] mst_HTRANS;
  logic [8:0] mst_HBURST;
  logic [2:0] mst_HMASTLOCK;
  logic       HREADY;
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       arb_locked;

  ahb3lite_slave_port_arbiter #(.MASTERS(3), .PRIORITY_BITS(3)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .mst_req       (mst_req),
    .mst_priority  (mst_priority),
    .mst_HTRANS    (mst_HTRANS),
    .mst_HBURST    (mst_HBURST),
    .mst_HMASTLOCK (mst_HMASTLOCK),
    .HREADY        (HREADY),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid),
    .arb_locked    (arb_locked)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [2:0] req;
    logic [8:0] prio;
    logic [5:0] trans;
    logic [8:0] burst;
    logic [2:0] lock;
    logic       hready;
    logic       rstn;
    logic [2:0] eg;
    logic       ev;
    logic       el;
    logic [1:0] ei;
  } vec_t;

  typedef struct {
    logic [2:0] g;
    logic       v;
    logic       l;
    logic [1:0] i;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [8:0] p3(input int a0, input int a1, input int a2);
    logic [8:0] r;
    r[2:0] = a0[2:0];
    r[5:3] = a1[2:0];
    r[8:6] = a2[2:0];
    return r;
  endfunction

  function automatic logic [5:0] t3(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [8:0] b3(input int a0, input int a1, input int a2);
    logic [8:0] r;
    r[2:0] = a0[2:0];
    r[5:3] = a1[2:0];
    r[8:6] = a2[2:0];
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] req, input logic [8:0] prio, input logic [5:0] trans,
                              input logic [8:0] burst, input logic [2:0] lock, input logic hready,
                              input logic rstn, input logic [2:0] eg, input logic ev, input logic el,
                              input logic [1:0] ei);
    vec_t x;
    x.req = req; x.prio = prio; x.trans = trans; x.burst = burst; x.lock = lock;
    x.hready = hready; x.rstn = rstn; x.eg = eg; x.ev = ev; x.el = el; x.ei = ei;
    return x;
  endfunction

  task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s step %0d: got %0h required %0h", nm, id, act, req_v);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare just after the edge
  task automatic step(input vec_t x, input int id);
    exp_t e;
    exp_t got;
    @(negedge HCLK);
    HRESETn       = x.rstn;
    mst_req       = x.req;
    mst_priority  = x.prio;
    mst_HTRANS    = x.trans;
    mst_HBURST    = x.burst;
    mst_HMASTLOCK = x.lock;
    HREADY        = x.hready;
    e.g = x.eg; e.v = x.ev; e.l = x.el; e.i = x.ei; e.id = id;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
    got = sb.pop_front();
    chk("grant",       got.id, {1'b0, grant},     {1'b0, got.g});
    chk("grant_valid", got.id, {3'b0, grant_valid}, {3'b0, got.v});
    chk("arb_locked",  got.id, {3'b0, arb_locked},  {3'b0, got.l});
    chk("grant_idx",   got.id, {2'b0, grant_idx},   {2'b0, got.i});
    $display("step %0d: grant=%b idx=%0d valid=%b locked=%b", got.id, grant, grant_idx, grant_valid, arb_locked);
  endtask

  initial begin
    HRESETn = 1'b0; mst_req = '0; mst_priority = '0; mst_HTRANS = '0;
    mst_HBURST = '0; mst_HMASTLOCK = '0; HREADY = 1'b1;

    // Reset state, then a single request granted with one cycle of latency
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 1, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b010, p3(0,0,0), t3(TI,TN,TI), b3(SGL,SGL,SGL), 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
    vecs.push_back(mk(3'b000, p3(0,0,0), t3(TI,TI,TI), 9'd0, 3'b000, 1, 1, 3'b000, 0, 0, 2'd1));
    // Equal-priority tie between m1 and m2
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b111, p3(1,5,5), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
`ifdef AHB_ARB_ROUND_ROBIN_EN
    vecs.push_back(mk(3'b111, p3(1,5,5), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b100, 1, 0, 2'd2));
`else
    vecs.push_back(mk(3'b111, p3(1,5,5), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
`endif
    vecs.push_back(mk(3'b111, p3(1,5,5), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
    // SEQ from the owner is not an arbitration point, so the new priority is ignored
    vecs.push_back(mk(3'b111, p3(7,5,5), t3(TS,TS,TS), 9'd0, 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
    vecs.push_back(mk(3'b111, p3(7,5,5), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b001, 1, 0, 2'd0));
    // INCR4 on m0 is held for 4 beats against a higher-priority m2
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b001, p3(1,0,6), t3(TN,TI,TI), b3(INC4,0,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(3'b101, p3(1,0,6), t3(TS,TI,TN), b3(INC4,0,SGL), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0));
    vecs.push_back(mk(3'b101, p3(1,0,6), t3(TS,TI,TN), b3(INC4,0,SGL), 3'b000, 1, 1, 3'b100, 1, 0, 2'd2));
    // Locked m1 across two INCR bursts against m0 at priority 7
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b010, p3(7,2,0), t3(TI,TN,TI), b3(0,INC,0), 3'b010, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b011, p3(7,2,0), t3(TN,TS,TI), b3(0,INC,0), 3'b010, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b011, p3(7,2,0), t3(TN,TN,TI), b3(0,INC,0), 3'b010, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b011, p3(7,2,0), t3(TN,TS,TI), b3(0,INC,0), 3'b010, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b011, p3(7,2,0), t3(TN,TN,TI), b3(0,INC,0), 3'b000, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b001, p3(7,2,0), t3(TN,TI,TI), b3(0,INC,0), 3'b000, 1, 1, 3'b001, 1, 0, 2'd0));
    // Early burst termination by a new NONSEQ
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b001, p3(1,3,0), t3(TN,TI,TI), b3(INC8,0,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0));
    vecs.push_back(mk(3'b011, p3(1,3,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0));
    vecs.push_back(mk(3'b011, p3(1,3,0), t3(TN,TN,TI), b3(SGL,SGL,0), 3'b000, 1, 1, 3'b010, 1, 0, 2'd1));
    // Reset during LOCK, then the first tie goes to m0
    vecs.push_back(mk(3'b010, p3(1,3,0), t3(TI,TN,TI), b3(0,SGL,0), 3'b010, 1, 1, 3'b010, 1, 1, 2'd1));
    vecs.push_back(mk(3'b010, p3(1,3,0), t3(TI,TN,TI), b3(0,SGL,0), 3'b010, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b111, p3(4,4,4), t3(TN,TN,TN), 9'd0, 3'b000, 1, 1, 3'b001, 1, 0, 2'd0));
    // HREADY low in IDLE: the request is ignored until HREADY returns
    vecs.push_back(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b100, p3(0,0,2), t3(TI,TI,TN), 9'd0, 3'b000, 0, 1, 3'b000, 0, 0, 2'd0));
    vecs.push_back(mk(3'b100, p3(0,0,2), t3(TI,TI,TN), 9'd0, 3'b000, 1, 1, 3'b100, 1, 0, 2'd2));

    for (int k = 0; k < vecs.size(); k++) step(vecs[k], k);

    // INCR8 on m0 stalled by HREADY=0 for 5 cycles at beat_cnt=4, plus one BUSY
    step(mk(3'b000, 9'd0, 6'd0, 9'd0, 3'b000, 1, 0, 3'b000, 0, 0, 2'd0), 200);
    step(mk(3'b001, p3(1,6,0), t3(TN,TI,TI), b3(INC8,0,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0), 201);
    for (int k = 0; k < 3; k++)
      step(mk(3'b011, p3(1,6,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0), 202 + k);
    for (int k = 0; k < 5; k++)
      step(mk(3'b011, p3(k % 8,7,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 0, 1, 3'b001, 1, 1, 2'd0), 210 + k);
    step(mk(3'b011, p3(1,6,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0), 220);
    step(mk(3'b011, p3(1,6,0), t3(TB,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0), 221);
    for (int k = 0; k < 3; k++)
      step(mk(3'b011, p3(1,6,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b001, 1, 1, 2'd0), 222 + k);
    step(mk(3'b011, p3(1,6,0), t3(TS,TN,TI), b3(INC8,SGL,0), 3'b000, 1, 1, 3'b010, 1, 0, 2'd1), 230);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
